seq_gcd_stein: RTL

Parametrised iterative GCD engine using the binary (Stein) algorithm: shifts and subtracts only, no modulo or divider in the datapath. Operand width is set by a parameter. Operands enter through a valid/ready handshake and the result leaves through one. A synchronous abort is provided. It is the successor to the single-width, modulo-based, LA-triggered GCD in the user project and sits between the wishbone/LA register front end and the result readback registers.

---
 rtl/seq_gcd_stein.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_gcd_stein.sv
// Iterative binary (Stein) GCD engine with valid/ready handshakes on operands and result.
// Optional macro GCD_CYCLE_CNT_EN adds the cycles_o port reporting CALC cycles of the last result.
module seq_gcd_stein #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_o,
    output logic             busy_o
`ifdef GCD_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cycles_o
`endif
);

    localparam int K_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [K_W-1:0]   k;
    logic             finish;

    assign finish    = (a == '0) || (b == '0) || (a == b);
    // in_ready is gated by rst_n so the engine never advertises readiness while held in reset.
    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign busy_o    = (state == CALC);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = CALC;
            CALC: begin
                if (abort_i)     state_next = IDLE;
                else if (finish) state_next = DONE;
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a     <= '0;
            b     <= '0;
            k     <= '0;
            gcd_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a <= a_i;
                        b <= b_i;
                        k <= '0;
                    end
                end
                CALC: begin
                    if (!abort_i) begin
                        if (finish) begin
                            // The true GCD fits in WIDTH bits, so shifting back by k cannot overflow.
                            gcd_o <= (a | b) << k;
                        end else if (!a[0] && !b[0]) begin
                            a <= a >> 1;
                            b <= b >> 1;
                            k <= k + K_W'(1);
                        end else if (!a[0]) begin
                            a <= a >> 1;
                        end else if (!b[0]) begin
                            b <= b >> 1;
                        end else if (a > b) begin
                            a <= (a - b) >> 1;
                        end else begin
                            b <= (b - a) >> 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GCD_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // cnt_next includes the cycle currently executing, so a finishing step reports the full count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            cycles_o <= '0;
        end else if (state == IDLE) begin
            if (in_valid) cnt <= '0;
        end else if (state == CALC) begin
            cnt <= cnt_next;
            if (!abort_i && finish) cycles_o <= cnt_next;
        end
    end
`endif

endmodule
